adder_arbiter: RTL and testbench

Shares one 32-bit adder among `N_REQ` requesters, such as PC+4, branch-target and address generation, in the pipelined processor. Each requester presents an operand pair with a valid/ready handshake. A round-robin scheduler grants one requester per cycle. The sum, carry-out, signed-overflow flag and requester ID return through a single registered response channel with back-pressure.

---
 rtl/adder_arb_pkg.sv | 12 +
 rtl/adder.sv | 10 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_arbiter.sv | 61 ++++++
 tb/tb_adder_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared constants and response type for the adder arbiter
package adder_arb_pkg;
    localparam int WIDTH = 32;
    localparam int N_REQ_MAX = 8;
    typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        req_id_t          id;
    } adder_rsp_t;
endpackage

// File: rtl/adder.sv
// adder: plain combinational adder shared by all requesters
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr, ptr advances past each winner
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);
    logic [IW-1:0] ptr;
    logic          found;
    always_comb begin
        found = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                grant_idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
        grant = (found && enable) ? N_REQ'(1) << grant_idx : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (|grant)
            ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: one 32-bit adder shared round-robin among N_REQ requesters
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IW-1:0]               rsp_id,
    output logic [WIDTH-1:0]            rsp_sum,
    output logic                        rsp_carry,
    output logic                        rsp_ovf
);
    adder_rsp_t       rsp_q, rsp_d;
    logic [IW-1:0]    gidx;
    logic [WIDTH-1:0] op_a, op_b, sum;
    // Gating with rst keeps req_ready low for the whole reset assertion
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .enable    (rst && (!rsp_valid || rsp_ready)),
        .grant     (req_ready),
        .grant_idx (gidx)
    );
    assign op_a = req_a[gidx];
    assign op_b = req_b[gidx];
    adder #(.W(WIDTH)) u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );
    always_comb begin
        rsp_d.sum = sum;
        rsp_d.carry = (op_a[WIDTH-1] & op_b[WIDTH-1]) | ((op_a[WIDTH-1] ^ op_b[WIDTH-1]) & ~sum[WIDTH-1]);
        rsp_d.ovf = (op_a[WIDTH-1] ~^ op_b[WIDTH-1]) & (op_a[WIDTH-1] ^ sum[WIDTH-1]);
        rsp_d.id = req_id_t'(gidx);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_q <= '0;
        end else if (|req_ready) begin
            rsp_valid <= 1'b1;
            rsp_q <= rsp_d;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
    assign rsp_sum = rsp_q.sum;
    assign rsp_carry = rsp_q.carry;
    assign rsp_ovf = rsp_q.ovf;
    assign rsp_id = rsp_q.id[IW-1:0];
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized and directed checks against a behavioural model
module tb_adder_arbiter;
    localparam int N = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N-1:0][31:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_carry, rsp_ovf;
    logic [1:0] rsp_id;
    logic [31:0] rsp_sum;
    int vectors = 0, errors = 0;
    int m_ptr, m_id;
    bit m_valid, m_carry, m_ovf;
    logic [31:0] m_sum;

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
    );

    function automatic int pick(logic [N-1:0] v, int p, bit can);
        if (!can) return -1;
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_sum = '0; m_carry = 0; m_ovf = 0; m_id = 0;
    endtask

    task automatic model_edge(input int g);
        logic [32:0] full;
        if (g >= 0) begin
            full = {1'b0, req_a[g]} + {1'b0, req_b[g]};
            m_sum = full[31:0];
            m_carry = full[32];
            m_ovf = (req_a[g][31] == req_b[g][31]) && (m_sum[31] != req_a[g][31]);
            m_id = g;
            m_valid = 1;
            m_ptr = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        #3;
        vectors++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b sum=%h c=%b o=%b id=%0d, required all zero", req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id);
        end
        req_valid = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_corner();
        int idx [3] = '{0, 2, 1};
        logic [31:0] a [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] b [3] = '{32'h8000_0001, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] s [3] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
        bit c [3] = '{1, 1, 0};
        bit o [3] = '{1, 0, 1};
        int g;
        for (int t = 0; t < 3; t++) begin
            req_valid = onehot(idx[t]);
            req_a[idx[t]] = a[t];
            req_b[idx[t]] = b[t];
            rsp_ready = 1'b1;
            #1;
            g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
            vectors++;
            if (req_ready !== onehot(idx[t])) begin
                errors++;
                $display("FAIL corner_grant[%0d]: got %b want %b", t, req_ready, onehot(idx[t]));
            end
            @(posedge clk);
            model_edge(g);
            #1;
            req_valid = '0;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_sum !== s[t] || rsp_carry !== c[t] || rsp_ovf !== o[t] || rsp_id !== 2'(idx[t])) begin
                errors++;
                $display("FAIL corner_rsp[%0d]: got v=%b sum=%h c=%b o=%b id=%0d want v=1 sum=%h c=%b o=%b id=%0d",
                         t, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id, s[t], c[t], o[t], idx[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = m_ptr;
        int g;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = rand_op();
            req_b[i] = rand_op();
        end
        for (int k = 0; k < 3 * N; k++) begin
            #1;
            g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
            vectors++;
            if (req_ready !== onehot((first + k) % N)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b want %b", k, req_ready, onehot((first + k) % N));
            end
            @(posedge clk);
            model_edge(g);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((first + k) % N) || rsp_sum !== m_sum || rsp_carry !== m_carry || rsp_ovf !== m_ovf) begin
                errors++;
                $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d sum=%h c=%b o=%b want v=1 id=%0d sum=%h c=%b o=%b",
                         k, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf, (first + k) % N, m_sum, m_carry, m_ovf);
            end
            if (g >= 0) begin
                req_a[g] = rand_op();
                req_b[g] = rand_op();
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h_sum = rsp_sum;
        logic [1:0] h_id = rsp_id;
        logic h_c = rsp_carry, h_o = rsp_ovf;
        int g;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
            vectors++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            @(posedge clk);
            model_edge(g);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_sum !== h_sum || rsp_id !== h_id || rsp_carry !== h_c || rsp_ovf !== h_o) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b sum=%h id=%0d c=%b o=%b want v=1 sum=%h id=%0d c=%b o=%b",
                         k, rsp_valid, rsp_sum, rsp_id, rsp_carry, rsp_ovf, h_sum, h_id, h_c, h_o);
            end
        end
        rsp_ready = 1'b1;
        #1;
        g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
        vectors++;
        if (req_ready !== onehot((int'(h_id) + 1) % N)) begin
            errors++;
            $display("FAIL bp_release_grant: got %b want %b", req_ready, onehot((int'(h_id) + 1) % N));
        end
        @(posedge clk);
        model_edge(g);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((int'(h_id) + 1) % N) || rsp_sum !== m_sum) begin
            errors++;
            $display("FAIL bp_release_rsp: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h",
                     rsp_valid, rsp_id, rsp_sum, (int'(h_id) + 1) % N, m_sum);
        end
    endtask

    task automatic test_mid_reset();
        int g;
        req_valid = '1;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b sum=%h c=%b o=%b id=%0d, required all zero", req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        #1;
        g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL restart_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        model_edge(g);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== m_sum) begin
            errors++;
            $display("FAIL restart_rsp: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", rsp_valid, rsp_id, rsp_sum, m_sum);
        end
    endtask

    task automatic test_random();
        bit pend [N];
        int waited [N];
        int g;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            waited[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    waited[i] = 0;
                    req_a[i] = rand_op();
                    req_b[i] = rand_op();
                end
            for (int i = 0; i < N; i++) req_valid[i] = pend[i];
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
            vectors++;
            if (req_ready !== onehot(g)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_ready, onehot(g));
            end
            @(posedge clk);
            model_edge(g);
            #1;
            vectors++;
            if (rsp_valid !== m_valid || rsp_sum !== m_sum || rsp_carry !== m_carry || rsp_ovf !== m_ovf || rsp_id !== 2'(m_id)) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: got v=%b sum=%h c=%b o=%b id=%0d want v=%b sum=%h c=%b o=%b id=%0d",
                         cyc, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id, m_valid, m_sum, m_carry, m_ovf, m_id);
            end
            if (g >= 0) begin
                for (int i = 0; i < N; i++) if (pend[i]) waited[i]++;
                vectors++;
                if (waited[g] > N) begin
                    errors++;
                    $display("FAIL rand_fair[%0d]: requester %0d waited %0d accepts, limit %0d", cyc, g, waited[g], N);
                end
                pend[g] = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_corner();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
